// File: rtl/transpose_stream_ctrl.sv
// Row-major in, column-major out stream controller for a circulant
// transpose buffer: fills a frame, then drains it through a 4-deep FIFO.
module transpose_stream_ctrl #(
  parameter int MATRIX_DIM = 4,
  parameter int COL_WIDTH  = 8,
  parameter int WORD_LEN   = 32,
  parameter int ADDR_LEN   = $clog2(MATRIX_DIM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WORD_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                mem_write_en,
  output logic [ADDR_LEN-1:0] mem_write_row,
  output logic [ADDR_LEN-1:0] mem_write_col,
  output logic [WORD_LEN-1:0] mem_data_in,
  output logic                mem_read_en,
  output logic [ADDR_LEN-1:0] mem_read_row,
  output logic [ADDR_LEN-1:0] mem_read_col,
  output logic                mem_barrel_shift_en,
  input  logic [WORD_LEN-1:0] mem_data_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int CPW = WORD_LEN / COL_WIDTH;
  localparam int WPR = MATRIX_DIM / CPW;
  localparam int FW  = MATRIX_DIM * WPR;
  localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW  = $clog2(FW + 1);

  localparam logic [WW-1:0]       WLAST = WW'(WPR - 1);
  localparam logic [ADDR_LEN-1:0] RLAST = ADDR_LEN'(MATRIX_DIM - 1);
  localparam logic [RW-1:0]       FWC   = RW'(FW);

  typedef enum logic {FILL, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] wr_row_q, wr_row_d;
  logic [WW-1:0]       wr_word_q, wr_word_d;
  logic [ADDR_LEN-1:0] rd_col_q, rd_col_d;
  logic [WW-1:0]       rd_grp_q, rd_grp_d;
  logic [RW-1:0]       issued_q, issued_d;
  logic                v1_q, v2_q;
  logic [WORD_LEN-1:0] fifo_q [4];
  logic [1:0]          wp_q, rp_q;
  logic [2:0]          cnt_q;
  logic [2:0]          credit;
  logic                issue, push, pop;

  // Outstanding words = reads still in the memory pipe plus FIFO contents.
  assign credit = 3'(v1_q) + 3'(v2_q) + cnt_q;
  assign push   = v2_q;
  assign out_data = fifo_q[rp_q];

  always_comb begin
    state_d   = state_q;
    wr_row_d  = wr_row_q;
    wr_word_d = wr_word_q;
    rd_col_d  = rd_col_q;
    rd_grp_d  = rd_grp_q;
    issued_d  = issued_q;
    issue     = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    frame_done   = 1'b0;
    out_valid    = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_barrel_shift_en = 1'b0;
    mem_data_in   = in_data;
    mem_write_row = wr_row_q;
    mem_write_col = ADDR_LEN'(32'(wr_word_q) * CPW);
    mem_read_row  = ADDR_LEN'(32'(rd_grp_q) * CPW);
    mem_read_col  = rd_col_q;
    if (!rst) begin
      out_valid = (cnt_q != 3'd0);
      unique case (state_q)
        FILL: begin
          in_ready = 1'b1;
          if (in_valid) begin
            mem_write_en = 1'b1;
            if (wr_word_q == WLAST) begin
              wr_word_d = '0;
              if (wr_row_q == RLAST) begin
                wr_row_d = '0;
                state_d  = DRAIN;
              end else begin
                wr_row_d = wr_row_q + 1'b1;
              end
            end else begin
              wr_word_d = wr_word_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          busy = 1'b1;
          if (credit < 3'd4 && issued_q != FWC) begin
            issue       = 1'b1;
            mem_read_en = 1'b1;
            mem_barrel_shift_en = 1'b1;
            issued_d = issued_q + 1'b1;
            if (rd_grp_q == WLAST) begin
              rd_grp_d = '0;
              rd_col_d = rd_col_q + 1'b1;
            end else begin
              rd_grp_d = rd_grp_q + 1'b1;
            end
          end
          if (issued_q == FWC && !v1_q && !v2_q &&
              cnt_q == 3'd1 && out_ready) begin
            frame_done = 1'b1;
            state_d    = FILL;
            issued_d   = '0;
            rd_col_d   = '0;
            rd_grp_d   = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_row_q  <= '0;
      wr_word_q <= '0;
      rd_col_q  <= '0;
      rd_grp_q  <= '0;
      issued_q  <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_row_q  <= wr_row_d;
      wr_word_q <= wr_word_d;
      rd_col_q  <= rd_col_d;
      rd_grp_q  <= rd_grp_d;
      issued_q  <= issued_d;
      v1_q      <= issue;
      v2_q      <= v1_q;
      if (push) wp_q <= wp_q + 2'd1;
      if (pop)  rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_q + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wp_q] <= mem_data_out;
  end

endmodule
